// File: rtl/pipe_addsub.sv
// pipe_addsub: slice-pipelined adder/subtractor, SLICE bits resolved per stage, valid/ready flow control
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SLICE;
  logic [STAGES-1:0]            valid_q, valid_d, c_q, c_d, ci;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, si;
  logic [STAGES-1:0][SLICE:0]   r;
  logic                         ovf_q, ovf_d, adv;
  assign adv       = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = ovf_q;
  // a_d/b_d double as each stage's operand inputs; B is pre-inverted at entry for subtraction
  always_comb begin
    valid_d[0] = in_valid;
    a_d[0]     = a;
    b_d[0]     = sub ? ~b : b;
    si[0]      = '0;
    ci[0]      = sub ? 1'b1 : c_in;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
      si[k]      = s_q[k-1];
      ci[k]      = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r[k]   = {1'b0, a_d[k][k*SLICE +: SLICE]} + {1'b0, b_d[k][k*SLICE +: SLICE]} + {{SLICE{1'b0}}, ci[k]};
      s_d[k] = si[k];
      s_d[k][k*SLICE +: SLICE] = r[k][SLICE-1:0];
      c_d[k] = r[k][SLICE];
    end
    ovf_d = a_d[STAGES-1][WIDTH-1] ^ b_d[STAGES-1][WIDTH-1] ^ s_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
